// File: rtl/rom_stream_reader.sv
// rom_stream_reader: fetches a contiguous run of ROM words and streams them over valid/ready.
// Backpressure relies on the ROM holding Q while CEN is high, so there is no data buffer.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_cen_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0] cnt;
  logic valid, last, done, issue, hs;
  assign hs = valid && ready_i;
  assign issue = state == RUN && cnt != '0 && !abort_i && (!valid || ready_i);
  assign rom_cen_o = !issue;
  assign rom_addr_o = addr;
  assign data_o = rom_q_i;
  assign valid_o = valid;
  assign last_o = last;
  assign done_o = done;
  assign busy_o = state == RUN;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((start_i && num_words_i != '0) ? RUN : IDLE)
                             : ((abort_i || (hs && last)) ? IDLE : RUN);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr <= '0;
      cnt <= '0;
      valid <= 1'b0;
      last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == IDLE ? start_i && num_words_i == '0 : !abort_i && hs && last;
      if (state == IDLE && start_i) begin
        addr <= base_addr_i;
        cnt <= num_words_i;
      end else if (issue) begin
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
      end else if (state == RUN && abort_i) begin
        cnt <= '0;
      end
      // Abort drops the word in flight; the ROM was not accessed this cycle.
      if (state == RUN && abort_i) begin
        valid <= 1'b0;
        last <= 1'b0;
      end else if (issue) begin
        valid <= 1'b1;
        last <= cnt == CNT_WIDTH'(1);
      end else if (hs) begin
        valid <= 1'b0;
        last <= 1'b0;
      end
    end
  end
endmodule
